// File: rtl/alu_req_driver_if.sv
// rtl/alu_req_driver_if.sv - signal bundle between alu_req_driver and its environment
//
// Purpose: carries the command input stream, the ALU request/response
// handshakes, the downstream response stream and the status outputs.
// Modports:
//   master - the driver side (alu_req_driver itself)
//   slave  - the environment side (command source, ALU, response sink)
// Signals:
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op         command input
//   alu_in_valid/alu_in_ready/alu_a/alu_b/alu_op   request to the ALU
//   alu_out_valid/alu_out_ready/alu_result         result from the ALU
//   rsp_valid/rsp_ready/rsp_data/rsp_mismatch      downstream response
//   err_timeout/txn_count/mismatch_count           status
interface alu_req_driver_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 3,
  parameter int CNT_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic [OP_WIDTH-1:0]   cmd_op;

  logic                  alu_in_valid;
  logic                  alu_in_ready;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [OP_WIDTH-1:0]   alu_op;

  logic                  alu_out_valid;
  logic                  alu_out_ready;
  logic [DATA_WIDTH-1:0] alu_result;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_mismatch;

  logic                  err_timeout;
  logic [CNT_WIDTH-1:0]  txn_count;
  logic [CNT_WIDTH-1:0]  mismatch_count;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_in_ready, alu_out_valid, alu_result, rsp_ready,
    output cmd_ready, alu_in_valid, alu_a, alu_b, alu_op, alu_out_ready,
    output rsp_valid, rsp_data, rsp_mismatch,
    output err_timeout, txn_count, mismatch_count
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_in_ready, alu_out_valid, alu_result, rsp_ready,
    input  cmd_ready, alu_in_valid, alu_a, alu_b, alu_op, alu_out_ready,
    input  rsp_valid, rsp_data, rsp_mismatch,
    input  err_timeout, txn_count, mismatch_count
  );
endinterface

// File: rtl/alu_req_driver.sv
// rtl/alu_req_driver.sv - command FIFO and one-at-a-time request driver for the valid/ready ALU
//
// Purpose: buffers (a, b, op) commands, issues them to the ALU one at a time,
// forwards each result downstream, flags ALU stalls with a timeout abort and
// keeps saturating transaction statistics.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - alu_req_driver_if.master (command, ALU, response and status signals)
// Optional feature: define ALU_DRV_CHECK_EN to build the golden-model check
// (rsp_mismatch, mismatch_count); otherwise both are tied to 0.
module alu_req_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 3,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic clk,
  input  logic rst,
  alu_req_driver_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] mem_a  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b  [DEPTH];
  logic [OP_WIDTH-1:0]   mem_op [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_count;

  logic [DATA_WIDTH-1:0] iss_a, iss_b;
  logic [OP_WIDTH-1:0]   iss_op;

  logic [TMO_W-1:0]      tmo_cnt;
  logic                  tmo_hit;
  logic                  err_timeout_q;
  logic [CNT_WIDTH-1:0]  txn_count_q;

  logic push, pop;
  logic alu_in_valid_c, alu_out_ready_c, rsp_valid_c;
  logic [DATA_WIDTH-1:0] rsp_data_c;
  logic done, abort, tick;

  // Ready comes from the registered count only; a full FIFO never accepts,
  // even if the head is popped in the same cycle.
  assign bus.cmd_ready = (fifo_count < (PTR_W + 1)'(DEPTH));
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop  = (state == IDLE) && (fifo_count != '0);

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_comb begin
    next_state      = state;
    alu_in_valid_c  = 1'b0;
    alu_out_ready_c = 1'b0;
    rsp_valid_c     = 1'b0;
    rsp_data_c      = '0;
    done            = 1'b0;
    abort           = 1'b0;
    tick            = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) next_state = ISSUE;
      end
      ISSUE: begin
        alu_in_valid_c = 1'b1;
        if (bus.alu_in_ready) begin
          next_state = WAIT_RSP;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          tick = 1'b1;
        end
      end
      WAIT_RSP: begin
        // The ALU result passes straight through; downstream back-pressure
        // is handed to the ALU and does not count toward the timeout.
        alu_out_ready_c = bus.rsp_ready;
        rsp_valid_c     = bus.alu_out_valid;
        rsp_data_c      = bus.alu_result;
        if (bus.alu_out_valid && bus.rsp_ready) begin
          done       = 1'b1;
          next_state = IDLE;
        end else if (!bus.alu_out_valid) begin
          if (tmo_hit) begin
            abort      = 1'b1;
            next_state = IDLE;
          end else begin
            tick = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      iss_a         <= '0;
      iss_b         <= '0;
      iss_op        <= '0;
      tmo_cnt       <= '0;
      err_timeout_q <= 1'b0;
      txn_count_q   <= '0;
    end else begin
      state <= next_state;

      if (push) begin
        mem_a[wr_ptr]  <= bus.cmd_a;
        mem_b[wr_ptr]  <= bus.cmd_b;
        mem_op[wr_ptr] <= bus.cmd_op;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        iss_a  <= mem_a[rd_ptr];
        iss_b  <= mem_b[rd_ptr];
        iss_op <= mem_op[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase

      // Any state change restarts the timeout window.
      if (next_state != state) tmo_cnt <= '0;
      else if (tick)           tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (abort) err_timeout_q <= 1'b1;

      if (done && (txn_count_q != '1)) txn_count_q <= txn_count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.alu_in_valid  = alu_in_valid_c;
  assign bus.alu_out_ready = alu_out_ready_c;
  assign bus.alu_a         = iss_a;
  assign bus.alu_b         = iss_b;
  assign bus.alu_op        = iss_op;
  assign bus.rsp_valid     = rsp_valid_c;
  assign bus.rsp_data      = rsp_data_c;
  assign bus.err_timeout   = err_timeout_q;
  assign bus.txn_count     = txn_count_q;

`ifdef ALU_DRV_CHECK_EN
  logic [DATA_WIDTH-1:0] expected;
  logic [CNT_WIDTH-1:0]  mismatch_count_q;

  function automatic logic [DATA_WIDTH-1:0] golden(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [OP_WIDTH-1:0]   op
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = b & DATA_WIDTH'(DATA_WIDTH - 1);
    case (op)
      OP_WIDTH'(0): golden = a + b;
      OP_WIDTH'(1): golden = a - b;
      OP_WIDTH'(2): golden = a & b;
      OP_WIDTH'(3): golden = a | b;
      OP_WIDTH'(4): golden = a ^ b;
      OP_WIDTH'(5): golden = a << sh;
      OP_WIDTH'(6): golden = a >> sh;
      default:      golden = '0;
    endcase
  endfunction

  // The expected value is captured alongside the issue registers so it
  // always belongs to the command currently outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected         <= '0;
      mismatch_count_q <= '0;
    end else begin
      if (pop) expected <= golden(mem_a[rd_ptr], mem_b[rd_ptr], mem_op[rd_ptr]);
      if (done && (bus.alu_result != expected) && (mismatch_count_q != '1))
        mismatch_count_q <= mismatch_count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.rsp_mismatch   = rsp_valid_c && (bus.alu_result != expected);
  assign bus.mismatch_count = mismatch_count_q;
`else
  assign bus.rsp_mismatch   = 1'b0;
  assign bus.mismatch_count = '0;
`endif

endmodule

// File: tb/tb_alu_req_driver.sv
// tb/tb_alu_req_driver.sv - self-checking bench for alu_req_driver
`timescale 1ns/1ps
module tb_alu_req_driver;
  localparam int DW      = 8;
  localparam int OW      = 3;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = 16;
`ifdef ALU_DRV_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_req_driver_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

  alu_req_driver #(
    .DATA_WIDTH(DW), .OP_WIDTH(OW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_txn = 0;

  bit alu_en  = 1'b0;
  bit corrupt = 1'b0;

  logic [7:0] got_data[$];
  bit         got_mm[$];

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int ia, ib, s;
    ia = a; ib = b; s = ib % 8;
    case (op)
      3'd0:    return 8'((ia + ib) % 256);
      3'd1:    return 8'((ia - ib + 256) % 256);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return 8'((ia * (2 ** s)) % 256);
      3'd6:    return 8'(ia / (2 ** s));
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural one-deep ALU: accepts when idle, answers one cycle later.
  assign bus.alu_in_ready = alu_en && !bus.alu_out_valid;
  always @(posedge clk) begin
    if (rst) begin
      bus.alu_out_valid <= 1'b0;
      bus.alu_result    <= 8'h00;
    end else begin
      if (bus.alu_out_valid && bus.alu_out_ready) bus.alu_out_valid <= 1'b0;
      if (bus.alu_in_valid && bus.alu_in_ready) begin
        bus.alu_out_valid <= 1'b1;
        bus.alu_result    <= (corrupt && bus.alu_op == 3'd4) ? 8'h00 : ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      got_data.push_back(bus.rsp_data);
      got_mm.push_back(bus.rsp_mismatch);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int guard = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op;
    @(negedge clk);
    while (!bus.cmd_ready && guard < 200) begin @(negedge clk); guard++; end
    checks++;
    if (!bus.cmd_ready) begin errors++; $display("FAIL send_cmd cmd_ready got 0 exp 1"); end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int n);
    int guard = 0;
    while (got_data.size() < n && guard < 500) begin @(negedge clk); guard++; end
    checks++;
    if (got_data.size() < n) begin errors++; $display("FAIL wait_rsps count got %0d exp %0d", got_data.size(), n); end
    @(negedge clk);
  endtask

  task automatic clear_q();
    got_data.delete(); got_mm.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready); end
    checks++;
    if ({bus.alu_in_valid, bus.alu_out_ready, bus.rsp_valid, bus.rsp_mismatch, bus.err_timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000",
        {bus.alu_in_valid, bus.alu_out_ready, bus.rsp_valid, bus.rsp_mismatch, bus.err_timeout});
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_data, bus.txn_count, bus.mismatch_count} !== '0) begin
      errors++; $display("FAIL reset_buses got a=%h b=%h op=%h d=%h t=%h m=%h exp all 0",
        bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_data, bus.txn_count, bus.mismatch_count);
    end
  endtask

  task automatic test_add();
    clear_q(); alu_en = 1'b1; bus.rsp_ready = 1'b1;
    send_cmd(8'h0F, 8'h01, 3'd0);
    @(negedge clk);
    checks++;
    if (bus.alu_in_valid !== 1'b0) begin errors++; $display("FAIL add_pop_cycle alu_in_valid got %b exp 0", bus.alu_in_valid); end
    @(negedge clk);
    checks++;
    if ({bus.alu_in_valid, bus.alu_a, bus.alu_b, bus.alu_op} !== {1'b1, 8'h0F, 8'h01, 3'd0}) begin
      errors++; $display("FAIL add_issue got v=%b a=%h b=%h op=%h exp v=1 a=0f b=01 op=0",
        bus.alu_in_valid, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    wait_rsps(1);
    exp_txn = 1;
    checks++;
    if (got_data[0] !== 8'h10) begin errors++; $display("FAIL add_data got %h exp 10", got_data[0]); end
    checks++;
    if (got_mm[0] !== 1'b0) begin errors++; $display("FAIL add_mismatch got %b exp 0", got_mm[0]); end
    checks++;
    if (bus.txn_count !== CW'(exp_txn)) begin errors++; $display("FAIL add_txn got %0d exp %0d", bus.txn_count, exp_txn); end
  endtask

  task automatic test_sub_shl();
    clear_q();
    send_cmd(8'h00, 8'h01, 3'd1);
    send_cmd(8'h81, 8'h09, 3'd5);
    wait_rsps(2);
    exp_txn += 2;
    checks++;
    if (got_data.size() != 2 || got_data[0] !== 8'hFF || got_data[1] !== 8'h02) begin
      errors++; $display("FAIL sub_shl_order got %h %h exp ff 02", got_data[0], got_data[1]);
    end
    checks++;
    if (bus.txn_count !== CW'(exp_txn)) begin errors++; $display("FAIL sub_shl_txn got %0d exp %0d", bus.txn_count, exp_txn); end
  endtask

  task automatic test_rsp_stall();
    int guard = 0;
    clear_q(); bus.rsp_ready = 1'b0;
    send_cmd(8'h3C, 8'h0F, 3'd2);
    while (!bus.rsp_valid && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (!bus.rsp_valid) begin errors++; $display("FAIL stall_rsp_valid got 0 exp 1"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.alu_out_ready, bus.rsp_data} !== {1'b1, 1'b0, 8'h0C}) begin
        errors++; $display("FAIL stall_hold cyc %0d got v=%b r=%b d=%h exp v=1 r=0 d=0c",
          i, bus.rsp_valid, bus.alu_out_ready, bus.rsp_data);
      end
    end
    checks++;
    if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL stall_no_timeout got %b exp 0", bus.err_timeout); end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.alu_out_ready !== 1'b1) begin errors++; $display("FAIL stall_release alu_out_ready got %b exp 1", bus.alu_out_ready); end
    wait_rsps(1);
    exp_txn += 1;
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 8'h0C) begin errors++; $display("FAIL stall_data got %h exp 0c", got_data[0]); end
    checks++;
    if (bus.txn_count !== CW'(exp_txn)) begin errors++; $display("FAIL stall_txn got %0d exp %0d", bus.txn_count, exp_txn); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] ca[6], cb[6];
    logic [2:0] co[6];
    clear_q(); alu_en = 1'b0; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      ca[i] = 8'($urandom); cb[i] = 8'($urandom); co[i] = 3'(i);
      bus.cmd_valid = 1'b1; bus.cmd_a = ca[i]; bus.cmd_b = cb[i]; bus.cmd_op = co[i];
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== (i < 5)) begin errors++; $display("FAIL full_ready push %0d got %b exp %b", i, bus.cmd_ready, i < 5); end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    alu_en = 1'b1;
    wait_rsps(5);
    exp_txn += 5;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_data[i] !== ref_alu(ca[i], cb[i], co[i])) begin
        errors++; $display("FAIL full_drain idx %0d got %h exp %h", i, got_data[i], ref_alu(ca[i], cb[i], co[i]));
      end
    end
    checks++;
    if (bus.txn_count !== CW'(exp_txn)) begin errors++; $display("FAIL full_txn got %0d exp %0d", bus.txn_count, exp_txn); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int guard = 0;
    clear_q(); alu_en = 1'b0;
    send_cmd(8'hA0, 8'h05, 3'd3);
    while (!bus.err_timeout && guard < 100) begin
      @(negedge clk);
      if (bus.alu_in_valid) n++;
      guard++;
    end
    checks++;
    if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", bus.err_timeout); end
    checks++;
    if (n != TIMEOUT) begin errors++; $display("FAIL timeout_issue_cycles got %0d exp %0d", n, TIMEOUT); end
    checks++;
    if (bus.alu_in_valid !== 1'b0) begin errors++; $display("FAIL timeout_idle alu_in_valid got %b exp 0", bus.alu_in_valid); end
    alu_en = 1'b1;
    send_cmd(8'h20, 8'h22, 3'd0);
    wait_rsps(1);
    repeat (4) @(negedge clk);
    exp_txn += 1;
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 8'h42) begin
      errors++; $display("FAIL timeout_next got n=%0d d=%h exp n=1 d=42", got_data.size(), got_data[0]);
    end
    checks++;
    if (bus.txn_count !== CW'(exp_txn)) begin errors++; $display("FAIL timeout_txn got %0d exp %0d", bus.txn_count, exp_txn); end
  endtask

  task automatic test_mismatch();
    clear_q(); corrupt = 1'b1;
    send_cmd(8'hF0, 8'h0F, 3'd4);
    wait_rsps(1);
    corrupt = 1'b0;
    exp_txn += 1;
    checks++;
    if (got_data[0] !== 8'h00) begin errors++; $display("FAIL mm_data got %h exp 00", got_data[0]); end
    checks++;
    if (got_mm[0] !== CHECK_EN) begin errors++; $display("FAIL mm_flag got %b exp %b", got_mm[0], CHECK_EN); end
    checks++;
    if (bus.mismatch_count !== CW'(CHECK_EN)) begin errors++; $display("FAIL mm_count got %0d exp %0d", bus.mismatch_count, CHECK_EN); end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    bit issued = 1'b0;
    clear_q(); bus.rsp_ready = 1'b0; alu_en = 1'b1;
    send_cmd(8'h11, 8'h22, 3'd0);
    send_cmd(8'h33, 8'h01, 3'd1);
    send_cmd(8'h44, 8'h02, 3'd5);
    while (!bus.rsp_valid && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (!bus.rsp_valid) begin errors++; $display("FAIL midrst_wait got rsp_valid 0 exp 1"); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    exp_txn = 0;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready got %b exp 1", bus.cmd_ready); end
    checks++;
    if ({bus.alu_in_valid, bus.alu_out_ready, bus.rsp_valid, bus.rsp_mismatch, bus.err_timeout,
         bus.alu_a, bus.rsp_data, bus.txn_count, bus.mismatch_count} !== '0) begin
      errors++; $display("FAIL midrst_outputs got iv=%b or=%b rv=%b mm=%b to=%b a=%h d=%h t=%0d m=%0d exp all 0",
        bus.alu_in_valid, bus.alu_out_ready, bus.rsp_valid, bus.rsp_mismatch, bus.err_timeout,
        bus.alu_a, bus.rsp_data, bus.txn_count, bus.mismatch_count);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    repeat (12) begin @(negedge clk); if (bus.alu_in_valid) issued = 1'b1; end
    checks++;
    if (issued || got_data.size() != 0) begin
      errors++; $display("FAIL midrst_fifo_empty got issued=%b rsps=%0d exp 0 0", issued, got_data.size());
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [7:0] exp_q[$];
    bit stop = 1'b0;
    clear_q(); corrupt = 1'b0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic [7:0] a, b;
          logic [2:0] op;
          a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
          exp_q.push_back(ref_alu(a, b, op));
          send_cmd(a, b, op);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        stop = 1'b1;
      end
      begin
        int g = 0;
        while (!stop && g < 20000) begin
          @(posedge clk); #1;
          alu_en        = ($urandom_range(0, 3) != 0);
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
          g++;
        end
      end
    join
    @(posedge clk); #1;
    alu_en = 1'b1; bus.rsp_ready = 1'b1;
    wait_rsps(N);
    exp_txn += N;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_mm[i] !== 1'b0) begin
        errors++; $display("FAIL rand_rsp idx %0d got d=%h mm=%b exp d=%h mm=0", i, got_data[i], got_mm[i], exp_q[i]);
      end
    end
    checks++;
    if ({bus.txn_count, bus.mismatch_count, bus.err_timeout} !== {CW'(exp_txn), CW'(0), 1'b0}) begin
      errors++; $display("FAIL rand_status got t=%0d m=%0d to=%b exp t=%0d m=0 to=0",
        bus.txn_count, bus.mismatch_count, bus.err_timeout, exp_txn);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_shl();
    test_rsp_stall();
    test_fifo_full();
    test_timeout();
    test_mismatch();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
